uart_tx_q: RTL and testbench

UART_TX_Q -- requirements
Module: uart_tx_q

---
 rtl/uart_tx_q.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_tx_q.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_q.sv
// uart_tx_q: FIFO-buffered UART transmitter with fixed one-cycle start latency and back-to-back frames.
// Defining UART_TX_BREAK_EN adds the brk input and line-break sequencing (BREAK/MARK states).
`timescale 1ns/1ps
module uart_tx_q #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int DI_WIDTH   = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef UART_TX_BREAK_EN
    input  logic                          brk,
`endif
    input  logic [DI_WIDTH-1:0]           din,
    input  logic                          din_vld,
    output logic                          rfd,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int DIV      = CLK_FREQ / BAUD_RATE;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW       = AW + 1;
    localparam int BW       = $clog2(DI_WIDTH);

    localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_RELOAD = CW'(STOP_LEN - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DI_WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL    = LW'(FIFO_DEPTH);
    localparam logic          PAR_ODD     = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK,
        MARK
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DI_WIDTH-1:0]  shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic [DI_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [DI_WIDTH-1:0]  head;
    logic                 full, empty, wr_en, pop, tick;

    // rfd deliberately ignores a same-cycle pop, so a full FIFO never accepts a write.
    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign wr_en = din_vld && !full;
    assign head  = mem_q[rd_ptr_q];
    assign tick  = (baud_q == '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !wr_en) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? baud_q : baud_q - 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                end else
`endif
                if (!empty) begin
                    pop = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    state_d = DATA;
                    baud_d  = BIT_RELOAD;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            state_d = PAR;
                            baud_d  = BIT_RELOAD;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            baud_d  = STOP_RELOAD;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        baud_d  = BIT_RELOAD;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end

            PAR: begin
                if (tick) begin
                    state_d = STOP;
                    baud_d  = STOP_RELOAD;
                    tx_d    = 1'b1;
                end
            end

            STOP: begin
                if (tick) begin
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        state_d = BREAK;
                        tx_d    = 1'b0;
                    end else
`endif
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            BREAK: begin
                tx_d = 1'b0;
                if (!brk) begin
                    state_d = MARK;
                    baud_d  = BIT_RELOAD;
                    tx_d    = 1'b1;
                end
            end

            // One full mark bit after a break before the line may start a new frame.
            MARK: begin
                tx_d = 1'b1;
                if (brk) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                end else if (tick) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            state_d = START;
            baud_d  = BIT_RELOAD;
            tx_d    = 1'b0;
            shreg_d = head;
            par_d   = (^head) ^ PAR_ODD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign rfd   = !full;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE);
    assign level = level_q;

endmodule

// File: tb/tb_uart_tx_q.sv
// Directed bench for uart_tx_q: three instances (no parity / even / odd+2 stop), DIV=10, FIFO depth 4.
`timescale 1ns/1ps
module tb_uart_tx_q;

    logic       clk;
    logic       rst;
    logic [7:0] din_v [3];
    logic [2:0] vld_v;
    logic [2:0] rfd_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] lvl_v [3];
    logic       brk_r;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_q #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DI_WIDTH(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .brk(brk_r),
`endif
        .din(din_v[0]), .din_vld(vld_v[0]), .rfd(rfd_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .level(lvl_v[0]));

    uart_tx_q #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DI_WIDTH(8),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .din(din_v[1]), .din_vld(vld_v[1]), .rfd(rfd_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .level(lvl_v[1]));

    uart_tx_q #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DI_WIDTH(8),
                .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .din(din_v[2]), .din_vld(vld_v[2]), .rfd(rfd_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .level(lvl_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called 1ns after an edge; the word is written on the next edge.
    task automatic write(input int u, input logic [7:0] w);
        din_v[u] = w;
        vld_v[u] = 1'b1;
        @(posedge clk); #1;
        vld_v[u] = 1'b0;
    endtask

    // Expects the first start-bit cycle on the next edge; checks tx and busy every cycle.
    task automatic check_frame(input int u, input logic [7:0] w, input bit has_par,
                               input bit pbit, input int stops, input string tag);
        int  nbits;
        int  b;
        logic e;
        nbits = 9 + (has_par ? 1 : 0) + stops;
        for (int j = 0; j < nbits * 10; j++) begin
            @(posedge clk); #1;
            b = j / 10;
            if (b == 0)                   e = 1'b0;
            else if (b <= 8)              e = w[b-1];
            else if (has_par && b == 9)   e = pbit;
            else                          e = 1'b1;
            chk({tag, "_tx"}, tx_v[u], e);
            chk({tag, "_busy"}, busy_v[u], 1'b1);
        end
    endtask

    task automatic wait_idle(input int u, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && busy_v[u]; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_idle"}, busy_v[u], 1'b0);
    endtask

    initial begin
        rst   = 1'b0;
        vld_v = '0;
        brk_r = 1'b0;
        for (int u = 0; u < 3; u++) din_v[u] = '0;
        #1 rst = 1'b1;
        #2;
        for (int u = 0; u < 3; u++) begin
            chk("rst_tx", tx_v[u], 1'b1);
            chk("rst_busy", busy_v[u], 1'b0);
            chk("rst_rfd", rfd_v[u], 1'b1);
            chk("rst_level", lvl_v[u], 3'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single word 0x64: bits 0,0,1,0,0,1,1,0; busy falls at k+101.
        write(0, 8'h64);
        chk("single_level", lvl_v[0], 3'd1);
        chk("single_busy0", busy_v[0], 1'b0);
        check_frame(0, 8'h64, 1'b0, 1'b0, 1, "single");
        @(posedge clk); #1;
        chk("single_end_busy", busy_v[0], 1'b0);
        chk("single_end_tx", tx_v[0], 1'b1);
        chk("single_end_level", lvl_v[0], 3'd0);

        // 0x07 has three ones: even parity bit 1 (110 cycles), odd parity bit 0 (120 cycles, 2 stops).
        write(1, 8'h07);
        check_frame(1, 8'h07, 1'b1, 1'b1, 1, "par_even");
        @(posedge clk); #1;
        chk("par_even_end", busy_v[1], 1'b0);
        write(2, 8'h07);
        check_frame(2, 8'h07, 1'b1, 1'b0, 2, "par_odd");
        @(posedge clk); #1;
        chk("par_odd_end", busy_v[2], 1'b0);

        // Five consecutive writes into depth-4 FIFO; sixth ignored; five back-to-back frames.
        write(0, 8'hA5);
        fork
            begin
                din_v[0] = 8'h3C; vld_v[0] = 1'b1;
                @(posedge clk); #1; din_v[0] = 8'hFF;
                @(posedge clk); #1; din_v[0] = 8'h00;
                @(posedge clk); #1; din_v[0] = 8'h81;
                @(posedge clk); #1;
                chk("full_level", lvl_v[0], 3'd4);
                chk("full_rfd", rfd_v[0], 1'b0);
                din_v[0] = 8'h55;
                @(posedge clk); #1;
                vld_v[0] = 1'b0;
                chk("full_ign_level", lvl_v[0], 3'd4);
                chk("full_ign_rfd", rfd_v[0], 1'b0);
            end
            begin
                check_frame(0, 8'hA5, 1'b0, 1'b0, 1, "b2b0");
                check_frame(0, 8'h3C, 1'b0, 1'b0, 1, "b2b1");
                check_frame(0, 8'hFF, 1'b0, 1'b0, 1, "b2b2");
                check_frame(0, 8'h00, 1'b0, 1'b0, 1, "b2b3");
                check_frame(0, 8'h81, 1'b0, 1'b0, 1, "b2b4");
            end
        join
        @(posedge clk); #1;
        chk("b2b_end_busy", busy_v[0], 1'b0);
        chk("b2b_end_level", lvl_v[0], 3'd0);

        // Level 2 with a write on the STOP->START pop edge keeps level at 2.
        write(0, 8'h11);
        din_v[0] = 8'h22; vld_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("sim_level1", lvl_v[0], 3'd1);
        din_v[0] = 8'h33;
        @(posedge clk); #1;
        vld_v[0] = 1'b0;
        chk("sim_level2", lvl_v[0], 3'd2);
        repeat (98) @(posedge clk);
        #1;
        chk("sim_pre_level", lvl_v[0], 3'd2);
        chk("sim_pre_tx", tx_v[0], 1'b1);
        din_v[0] = 8'h44; vld_v[0] = 1'b1;
        @(posedge clk); #1;
        vld_v[0] = 1'b0;
        chk("sim_pop_level", lvl_v[0], 3'd2);
        chk("sim_pop_tx", tx_v[0], 1'b0);
        wait_idle(0, 450, "sim");
        chk("sim_drain_level", lvl_v[0], 3'd0);

        // Reset during data bit 3 with two words queued.
        @(posedge clk); #1;
        write(0, 8'h00);
        din_v[0] = 8'hF0; vld_v[0] = 1'b1;
        @(posedge clk); #1;
        din_v[0] = 8'h0F;
        @(posedge clk); #1;
        vld_v[0] = 1'b0;
        repeat (43) @(posedge clk);
        #1;
        chk("rstmid_pre_tx", tx_v[0], 1'b0);
        chk("rstmid_pre_level", lvl_v[0], 3'd2);
        rst = 1'b1;
        #1;
        chk("rstmid_tx", tx_v[0], 1'b1);
        chk("rstmid_busy", busy_v[0], 1'b0);
        chk("rstmid_level", lvl_v[0], 3'd0);
        chk("rstmid_rfd", rfd_v[0], 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        write(0, 8'h5A);
        chk("post_rst_level", lvl_v[0], 3'd1);
        check_frame(0, 8'h5A, 1'b0, 1'b0, 1, "post_rst");
        @(posedge clk); #1;
        chk("post_rst_end_busy", busy_v[0], 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_quiet_busy", busy_v[0], 1'b0);
        chk("post_rst_quiet_tx", tx_v[0], 1'b1);

`ifdef UART_TX_BREAK_EN
        // brk rises mid-frame and stays 50 cycles; break follows STOP, then one mark bit.
        write(0, 8'hC3);
        fork
            begin
                din_v[0] = 8'h96; vld_v[0] = 1'b1;
                @(posedge clk); #1;
                vld_v[0] = 1'b0;
                repeat (69) @(posedge clk);
                #1 brk_r = 1'b1;
                repeat (50) @(posedge clk);
                #1 brk_r = 1'b0;
            end
            begin
                check_frame(0, 8'hC3, 1'b0, 1'b0, 1, "brk_f1");
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    chk("brk_tx", tx_v[0], 1'b0);
                    chk("brk_busy", busy_v[0], 1'b1);
                    chk("brk_level", lvl_v[0], 3'd1);
                end
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    chk("mark_tx", tx_v[0], 1'b1);
                    chk("mark_busy", busy_v[0], 1'b1);
                end
                check_frame(0, 8'h96, 1'b0, 1'b0, 1, "brk_f2");
            end
        join
        @(posedge clk); #1;
        chk("brk_end_busy", busy_v[0], 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
